// File: rtl/audioport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audioport_pkg
// Description : Shared types and constants for the audio port feed path.
// Revision    : 1.0 - initial release
// ============================================================================
package audioport_pkg;

    // One i2s frame in system clock cycles; default minimum play dwell.
    localparam int FRAME_CYCLES = 384;

    // Feed controller state encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRIME    = 2'd1,
        PLAY     = 2'd2,
        STOPPING = 2'd3
    } feed_state_t;

    // One stereo sample as buffered in the feed FIFO.
    typedef struct packed {
        logic [23:0] left;
        logic [23:0] right;
    } stereo_sample_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Stereo sample FIFO with fall-through on empty, accepts a
//               push while full when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
    import audioport_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  stereo_sample_t           i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output stereo_sample_t           o_pop_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int               c_AW         = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL_LEVEL = (c_AW + 1)'(DEPTH);

    stereo_sample_t   r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL_LEVEL);

    // A full FIFO still accepts a push when an entry leaves in the same cycle.
    assign w_do_push = i_push && !i_flush && (!w_full || i_pop);
    // Popping an empty FIFO is only real when the pushed entry falls through.
    assign w_do_pop  = i_pop && !i_flush && (!w_empty || w_do_push);

    assign o_pop_data = w_empty ? i_push_data : r_mem[r_rd_ptr];
    assign o_level    = r_level;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : i2s_feed_ctrl
// Description : Buffers stereo samples and sequences play/tick towards
//               i2s_unit, keeping play stable for a minimum dwell and
//               flagging requests served from an empty buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_feed_ctrl
    import audioport_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int PRIME_LEVEL     = 2,
    parameter int PLAY_MIN_CYCLES = FRAME_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_in,
    input  logic                         stop_in,
    input  logic                         clr_in,
    input  logic                         sample_valid_in,
    input  logic [23:0]                  sample0_in,
    input  logic [23:0]                  sample1_in,
    output logic                         sample_ready_out,
    input  logic                         req_in,
    output logic                         play_out,
    output logic                         tick_out,
    output logic [23:0]                  audio0_out,
    output logic [23:0]                  audio1_out,
    output logic                         underrun_out,
    output logic [$clog2(FIFO_DEPTH):0]  level_out
);

    localparam int c_LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_DWELL_W = (PLAY_MIN_CYCLES > 1) ? $clog2(PLAY_MIN_CYCLES) : 1;

    localparam logic [c_DWELL_W-1:0] c_DWELL_LOAD = c_DWELL_W'(PLAY_MIN_CYCLES - 1);
    localparam logic [c_LVL_W-1:0]   c_PRIME_LVL  = c_LVL_W'(PRIME_LEVEL);

    localparam logic [1:0] c_ST_IDLE     = IDLE;
    localparam logic [1:0] c_ST_PRIME    = PRIME;
    localparam logic [1:0] c_ST_PLAY     = PLAY;
    localparam logic [1:0] c_ST_STOPPING = STOPPING;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_DWELL_W-1:0]  r_dwell;
    logic                  r_play;
    logic                  r_tick;
    logic [23:0]           r_audio0;
    logic [23:0]           r_audio1;
    logic                  r_underrun;

    logic                  w_dwell_done;
    logic                  w_playing;
    logic                  w_play_nxt;
    logic                  w_stop_fall;
    logic                  w_serve;
    logic                  w_start_accept;
    logic                  w_push;
    logic                  w_underrun;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [c_LVL_W-1:0]    w_level;
    stereo_sample_t        w_push_data;
    stereo_sample_t        w_pop_data;

    assign w_dwell_done = (r_dwell == '0);
    assign w_playing    = (r_state == c_ST_PLAY) || (r_state == c_ST_STOPPING);
    // The falling cycle serves no request so tick never outlives play.
    assign w_stop_fall  = (r_state == c_ST_STOPPING) && w_dwell_done;
    assign w_serve      = req_in && w_playing && !w_stop_fall;

    assign w_push_data.left  = sample0_in;
    assign w_push_data.right = sample1_in;

    // Ready stays high at full when a request frees a slot; blocked while flushing.
    assign sample_ready_out = (!w_fifo_full || w_serve) && !w_stop_fall;
    assign w_push           = sample_valid_in && sample_ready_out;
    // An empty FIFO with a simultaneous push still delivers real data.
    assign w_underrun       = w_serve && w_fifo_empty && !w_push;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_sample_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_serve),
        .i_flush     (w_stop_fall),
        .o_pop_data  (w_pop_data),
        .o_level     (w_level),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Next-state logic; stop always dominates start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_in && !stop_in && w_dwell_done) begin
                    w_state_nxt = c_ST_PRIME;
                end
            end
            c_ST_PRIME: begin
                if (stop_in) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_level >= c_PRIME_LVL) begin
                    w_state_nxt = c_ST_PLAY;
                end
            end
            c_ST_PLAY: begin
                if (stop_in) begin
                    w_state_nxt = c_ST_STOPPING;
                end
            end
            c_ST_STOPPING: begin
                if (w_dwell_done) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_play_nxt     = (w_state_nxt == c_ST_PLAY) || (w_state_nxt == c_ST_STOPPING);
    assign w_start_accept = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_PRIME);

    // State, play level and dwell counter (reloaded on every play edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_play  <= 1'b0;
            r_dwell <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_play  <= w_play_nxt;
            if (w_play_nxt != r_play) begin
                r_dwell <= c_DWELL_LOAD;
            end else if (!w_dwell_done) begin
                r_dwell <= r_dwell - 1'b1;
            end
        end
    end

    // One-cycle tick with the popped sample, zeros on underrun or play fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick   <= 1'b0;
            r_audio0 <= '0;
            r_audio1 <= '0;
        end else begin
            r_tick <= w_serve;
            if (w_stop_fall) begin
                r_audio0 <= '0;
                r_audio1 <= '0;
            end else if (w_serve) begin
                if (w_underrun) begin
                    r_audio0 <= '0;
                    r_audio1 <= '0;
                end else begin
                    r_audio0 <= w_pop_data.left;
                    r_audio1 <= w_pop_data.right;
                end
            end
        end
    end

    // Sticky underrun flag; a new underrun beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (w_underrun) begin
            r_underrun <= 1'b1;
        end else if (clr_in || w_start_accept) begin
            r_underrun <= 1'b0;
        end
    end

    assign play_out     = r_play;
    assign tick_out     = r_tick;
    assign audio0_out   = r_audio0;
    assign audio1_out   = r_audio1;
    assign underrun_out = r_underrun;
    assign level_out    = w_level;

endmodule
`default_nettype wire

// File: tb/tb_i2s_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_feed_ctrl
// Description : Self-checking bench for i2s_feed_ctrl with a sample
//               scoreboard checked on every tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_feed_ctrl;

    localparam int DEPTH = 4;
    localparam int DWELL = 384;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        stop_in = 1'b0;
    logic        clr_in = 1'b0;
    logic        sample_valid_in = 1'b0;
    logic [23:0] sample0_in = '0;
    logic [23:0] sample1_in = '0;
    logic        sample_ready_out;
    logic        req_in = 1'b0;
    logic        play_out;
    logic        tick_out;
    logic [23:0] audio0_out;
    logic [23:0] audio1_out;
    logic        underrun_out;
    logic [2:0]  level_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int flush_at = -1;

    logic [47:0] m_q[$];
    logic [47:0] exp_q[$];
    logic [47:0] mon_e;

    i2s_feed_ctrl #(
        .FIFO_DEPTH      (DEPTH),
        .PRIME_LEVEL     (2),
        .PLAY_MIN_CYCLES (DWELL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_in         (start_in),
        .stop_in          (stop_in),
        .clr_in           (clr_in),
        .sample_valid_in  (sample_valid_in),
        .sample0_in       (sample0_in),
        .sample1_in       (sample1_in),
        .sample_ready_out (sample_ready_out),
        .req_in           (req_in),
        .play_out         (play_out),
        .tick_out         (tick_out),
        .audio0_out       (audio0_out),
        .audio1_out       (audio1_out),
        .underrun_out     (underrun_out),
        .level_out        (level_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard drain: every tick must carry the next expected sample.
    always @(negedge clk) begin
        if (rst_n && tick_out) begin
            check("tick_while_play", play_out, 1'b1);
            if (exp_q.size() == 0) begin
                check("tick_unexpected", tick_out, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("audio", {audio0_out, audio1_out}, mon_e);
            end
        end
    end

    // One cycle of stimulus; srv says whether the bench expects req to be served.
    task automatic step(input bit v, input logic [23:0] a, input logic [23:0] b,
                        input bit rq, input bit srv);
        bit          pop;
        bit          rdy;
        bit          push;
        logic [47:0] e;
        pop  = rq && srv;
        rdy  = (m_q.size() < DEPTH) || pop;
        push = v && rdy;
        sample_valid_in = v;
        sample0_in      = a;
        sample1_in      = b;
        req_in          = rq;
        if (pop) begin
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
            end else if (push) begin
                e    = {a, b};
                push = 1'b0;
            end else begin
                e = '0;
            end
            exp_q.push_back(e);
        end
        if (push) m_q.push_back({a, b});
        #2;
        if (v) check("ready", sample_ready_out, rdy);
        @(posedge clk);
        #1;
        if (cyc == flush_at) m_q.delete();
        sample_valid_in = 1'b0;
        sample0_in      = '0;
        sample1_in      = '0;
        req_in          = 1'b0;
        start_in        = 1'b0;
        stop_in         = 1'b0;
        clr_in          = 1'b0;
        check("tick", tick_out, pop);
        check("level", level_out, m_q.size());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_play", play_out, 1'b0);
        check("rst_tick", tick_out, 1'b0);
        check("rst_underrun", underrun_out, 1'b0);
        check("rst_level", level_out, 3'd0);
        check("rst_ready", sample_ready_out, 1'b1);
        check("rst_audio", {audio0_out, audio1_out}, 48'd0);
        rst_n = 1'b1;
        idle(1);
        step(1'b0, '0, '0, 1'b1, 1'b0);          // req in IDLE ignored

        // Priming
        step(1'b1, 24'h000001, 24'h000002, 1'b0, 1'b0);
        step(1'b1, 24'h000003, 24'h000004, 1'b0, 1'b0);
        check("prime_play_low", play_out, 1'b0);
        start_in = 1'b1;
        idle(1);
        check("prime_state_play_low", play_out, 1'b0);
        idle(1);
        check("play_rise", play_out, 1'b1);
        rise_cyc = cyc;

        // Request service and underrun
        step(1'b0, '0, '0, 1'b1, 1'b1);          // -> 000001/000002
        idle(1);
        step(1'b0, '0, '0, 1'b1, 1'b1);          // -> 000003/000004
        step(1'b0, '0, '0, 1'b1, 1'b1);          // underrun -> zeros
        check("underrun_set", underrun_out, 1'b1);
        idle(2);
        check("underrun_sticky", underrun_out, 1'b1);
        clr_in = 1'b1;
        step(1'b0, '0, '0, 1'b1, 1'b1);          // clear and underrun together
        check("underrun_set_wins", underrun_out, 1'b1);
        clr_in = 1'b1;
        idle(1);
        check("underrun_clr", underrun_out, 1'b0);

        // Early stop: play holds for the full dwell, STOPPING still serves
        while (cyc - rise_cyc < 10) idle(1);
        flush_at = rise_cyc + DWELL;
        stop_in  = 1'b1;
        step(1'b1, 24'h00000A, 24'h00000B, 1'b0, 1'b0);
        step(1'b1, 24'h00000C, 24'h00000D, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);          // served in STOPPING
        check("stopping_play", play_out, 1'b1);
        while (cyc - rise_cyc < DWELL - 1) idle(1);
        check("play_hold", play_out, 1'b1);
        idle(1);
        check("play_fall", play_out, 1'b0);
        check("fall_audio", {audio0_out, audio1_out}, 48'd0);
        fall_cyc = cyc;

        // Command edges: start during dwell, start+stop together
        step(1'b1, 24'h000011, 24'h000012, 1'b0, 1'b0);
        step(1'b1, 24'h000013, 24'h000014, 1'b1, 1'b0);   // req in IDLE ignored
        start_in = 1'b1;
        idle(3);
        check("start_in_dwell_ignored", play_out, 1'b0);
        while (cyc - fall_cyc < DWELL - 2) idle(1);
        start_in = 1'b1;                          // one cycle before dwell ends
        idle(3);
        check("start_late_dwell_ignored", play_out, 1'b0);
        start_in = 1'b1;
        stop_in  = 1'b1;
        idle(3);
        check("start_stop_stays_idle", play_out, 1'b0);
        start_in = 1'b1;
        idle(1);
        check("restart_prime", play_out, 1'b0);
        idle(1);
        check("restart_play", play_out, 1'b1);
        rise_cyc = cyc;

        // FIFO boundaries
        step(1'b1, 24'h000021, 24'h000022, 1'b0, 1'b0);
        step(1'b1, 24'h000023, 24'h000024, 1'b0, 1'b0);
        check("full_ready", sample_ready_out, 1'b0);
        step(1'b1, 24'h000025, 24'h000026, 1'b0, 1'b0);   // blocked push
        step(1'b1, 24'h000027, 24'h000028, 1'b1, 1'b1);   // push+pop at full
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(1);

        // Reset asserted mid-play
        step(1'b1, 24'h000031, 24'h000032, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        check("pre_reset_tick", tick_out, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_play", play_out, 1'b0);
        check("async_rst_tick", tick_out, 1'b0);
        check("async_rst_level", level_out, 3'd0);
        exp_q.delete();
        m_q.delete();
        flush_at = -1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("post_reset_play", play_out, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_feed_ctrl.md
Name: i2s_feed_ctrl

Overview:
- Sequencing controller in front of i2s_unit.
- Buffers stereo 24-bit samples from the upstream datapath in a small FIFO and drives i2s_unit's play and tick inputs.
- Answers each i2s data request with one tick pulse plus a stereo sample.
- Enforces the i2s_unit input contract (single-cycle tick, tick only while playing, play stable ≥ 384 cycles) and reports underruns.

Parameters:
FIFO_DEPTH, 4, stereo sample entries buffered (power of 2, ≥2)
PRIME_LEVEL, 2, entries required before play_out is raised (1..FIFO_DEPTH)
PLAY_MIN_CYCLES, 384, minimum cycles play_out holds a level after any change

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
start_in  in  1  single-cycle start command
stop_in  in  1  single-cycle stop command
clr_in  in  1  single-cycle clear of underrun_out
sample_valid_in  in  1  upstream sample valid
sample0_in  in  24  left sample
sample1_in  in  24  right sample
sample_ready_out  out  1  FIFO not full; push occurs when valid && ready
req_in  in  1  data request pulse from i2s_unit req_out
play_out  out  1  to i2s_unit play_in
tick_out  out  1  to i2s_unit tick_in
audio0_out  out  24  to i2s_unit audio0_in
audio1_out  out  24  to i2s_unit audio1_in
underrun_out  out  1  sticky: request served from empty FIFO
level_out  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: play_out, tick_out, underrun_out = 0; audio0/1_out = 0; FIFO empty; level_out = 0; sample_ready_out = 1; state IDLE; dwell counter = 0.
- Dwell counter: loaded to PLAY_MIN_CYCLES-1 on every play_out transition, decrements to 0. dwell_done = (counter == 0).
- IDLE (play_out=0):
  - start_in && dwell_done && !stop_in -> PRIME. underrun_out cleared.
  - start_in while !dwell_done is ignored; the command is not queued.
- PRIME (play_out=0):
  - stop_in -> IDLE.
  - level ≥ PRIME_LEVEL -> PLAY; play_out rises next cycle.
- PLAY (play_out=1):
  - Each req_in: pop one entry. Register it onto audio0/1_out and assert tick_out for exactly one cycle, 1 cycle after req_in.
  - If the FIFO is empty at req_in: audio0/1_out = 0, tick_out still pulses, underrun_out set.
  - stop_in -> STOPPING.
- STOPPING (play_out=1):
  - Keeps serving req_in exactly as PLAY.
  - When dwell_done: play_out falls, FIFO flushed, audio0/1_out = 0, go to IDLE.
  - start_in is ignored.
- tick_out is never asserted while play_out=0. A req_in arriving in IDLE or PRIME is ignored.
- FIFO:
  - Push and pop in the same cycle: level unchanged. Pop from empty in that cycle takes the pushed entry (fall-through).
  - Push when full is blocked by sample_ready_out=0; no overwrite.
  - Pointers wrap modulo FIFO_DEPTH.
  - Flush on the STOPPING->IDLE transition only.
- underrun_out: set has priority over clr_in in the same cycle. Cleared by clr_in or on IDLE->PRIME.
- Simultaneous start_in and stop_in: stop wins.
- Reset mid-play: all outputs drop immediately to reset values. The dwell rule does not apply to reset.

Decomposition:
- audioport_pkg gets:
  - FRAME_CYCLES = 384, the PLAY_MIN_CYCLES default
  - typedef enum feed_state_t {IDLE, PRIME, PLAY, STOPPING}
  - typedef struct stereo_sample_t {left[23:0], right[23:0]}
- One sub-module, sample_fifo: parameterised depth, stereo_sample_t data, push/pop/flush, level, full/empty.
- FSM, dwell counter and tick/output registers stay in i2s_feed_ctrl.

Test Plan:
- Start with priming: reset, push 0x000001/0x000002 and 0x000003/0x000004, then start_in -> play_out=1 within 2 cycles of level reaching 2; before that, play_out=0 and tick_out=0.
- Request service: in PLAY, pulse req_in -> next cycle tick_out=1 for 1 cycle with audio0_out=0x000001, audio1_out=0x000002; level_out decrements 2->1.
- Underrun: in PLAY with FIFO empty, req_in -> tick_out pulses with audio0/1_out=0 and underrun_out=1. It stays 1 until clr_in; clr_in and a new underrun in the same cycle -> stays 1.
- Early stop: stop_in 10 cycles after play_out rises -> play_out holds until exactly 384 cycles after its rise, then falls. A req_in during STOPPING is still served. Level is 0 after the fall.
- FIFO boundaries: fill to 4 -> sample_ready_out=0 and a 5th push is not accepted. Simultaneous push and req_in at level 4 -> level stays 4, data order preserved.
- Command edges: start_in and stop_in in the same cycle in IDLE -> stays IDLE. start_in within 384 cycles after play_out falls -> ignored. Reset asserted mid-PLAY -> play_out=0 and tick_out=0 asynchronously.
